// File: rtl/fft_pkg.sv
// Shared constants, sample type and index helpers for the 32-point FFT pipeline.
// Imported by the reorder buffer, its interface and the stimulus generators.
package fft_pkg;

  localparam int unsigned FFT_N      = 32;
  localparam int unsigned FFT_LOG2N  = 5;
  localparam int unsigned FFT_DATA_W = 22;

  typedef struct packed {
    logic signed [FFT_DATA_W-1:0] re;
    logic signed [FFT_DATA_W-1:0] im;
  } cplx_t;

  // b4b3b2b1b0 -> b0b1b2b3b4
  function automatic logic [4:0] bitrev5(input logic [4:0] x);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) begin
      r[i] = x[4-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_32_if.sv
// Sample stream bundle between the last FFT butterfly and the reorder buffer output.
// master drives bit-reversed samples and consumes the natural-order burst; slave is the buffer.
interface fft_reorder_32_if
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = FFT_DATA_W,
  parameter int unsigned LOG2_N = FFT_LOG2N
);

  logic                     in_valid;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_real;
  logic signed [DATA_W-1:0] out_imag;
  logic [LOG2_N-1:0]        out_index;
  logic                     out_last;

  modport master (
    output in_valid,
    output in_real,
    output in_imag,
    input  out_valid,
    input  out_real,
    input  out_imag,
    input  out_index,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_real,
    input  in_imag,
    output out_valid,
    output out_real,
    output out_imag,
    output out_index,
    output out_last
  );

endinterface

// File: rtl/fft_reorder_ram.sv
// One ping-pong bank: synchronous write port, registered read port.
// The read register loads zero when not enabled so idle banks contribute nothing downstream.
module fft_reorder_ram
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * FFT_DATA_W,
  parameter int unsigned DEPTH = FFT_N
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage array has no reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_reorder_32.sv
// Bit-reversed to natural-order reorder buffer: two 32-entry banks in ping-pong,
// bit-reversed write addressing and a read FSM replaying each full bank as a gapless burst.
module fft_reorder_32
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = FFT_DATA_W,
  parameter int unsigned LOG2_N = FFT_LOG2N
) (
  input  logic           clk,
  input  logic           rst_n,
  fft_reorder_32_if.slave bus
);

  localparam logic StIdle = 1'b0;
  localparam logic StRead = 1'b1;

  localparam logic [LOG2_N-1:0] LastIdx = '1;

  logic              state_q, state_d;
  logic [LOG2_N-1:0] wr_cnt_q;
  logic              wr_bank_q;
  logic [LOG2_N-1:0] rd_cnt_q, rd_cnt_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic [1:0]        set_vec;
  logic [1:0]        avail;
  logic              wr_done;
  logic              rd_en;
  logic              rd_bank_n;

  logic              out_valid_q;
  logic [LOG2_N-1:0] out_index_q;
  logic              out_last_q;

  logic [2*DATA_W-1:0] wr_data;
  logic [2*DATA_W-1:0] rd_data0, rd_data1, rd_data;

  // ---------------------------------------------------------------- write side
  assign wr_done = bus.in_valid && (wr_cnt_q == LastIdx);
  assign set_vec = wr_done ? (2'b01 << wr_bank_q) : 2'b00;
  assign wr_data = {bus.in_real, bus.in_imag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
    end else if (bus.in_valid) begin
      wr_cnt_q <= wr_cnt_q + 1'b1;
      if (wr_done) begin
        wr_bank_q <= ~wr_bank_q;
      end
    end
  end

  // ---------------------------------------------------------------- read FSM
  // A bank completing this very cycle counts as full, for both start and continuation.
  assign avail     = full_q | set_vec;
  assign rd_en     = (state_q == StRead);
  assign rd_bank_n = ~rd_bank_q;

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q | set_vec;
    unique case (state_q)
      StIdle: begin
        // Banks fill and drain strictly alternately, so rd_bank_q already names the oldest.
        if (avail[rd_bank_q]) begin
          state_d  = StRead;
          rd_cnt_d = '0;
        end
      end
      StRead: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LastIdx) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = rd_bank_n;
          if (!avail[rd_bank_n]) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
    end
  end

  // ---------------------------------------------------------------- output side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= rd_en;
      out_index_q <= rd_en ? rd_cnt_q : '0;
      out_last_q  <= rd_en && (rd_cnt_q == LastIdx);
    end
  end

  fft_reorder_ram #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FFT_N)
  ) u_ram0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.in_valid && !wr_bank_q),
    .wr_addr (bitrev5(wr_cnt_q)),
    .wr_data (wr_data),
    .rd_en   (rd_en && !rd_bank_q),
    .rd_addr (rd_cnt_q),
    .rd_data (rd_data0)
  );

  fft_reorder_ram #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FFT_N)
  ) u_ram1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.in_valid && wr_bank_q),
    .wr_addr (bitrev5(wr_cnt_q)),
    .wr_data (wr_data),
    .rd_en   (rd_en && rd_bank_q),
    .rd_addr (rd_cnt_q),
    .rd_data (rd_data1)
  );

  // Unselected bank registers hold zero, so an OR of the two is the selected word (or zero).
  assign rd_data = rd_data0 | rd_data1;

  assign bus.out_valid = out_valid_q;
  assign bus.out_real  = rd_data[2*DATA_W-1:DATA_W];
  assign bus.out_imag  = rd_data[DATA_W-1:0];
  assign bus.out_index = out_index_q;
  assign bus.out_last  = out_last_q;

  // Filling a bank takes at least as long as draining the other one.
  assert property (@(posedge clk) disable iff (!rst_n) !(bus.in_valid && full_q[wr_bank_q]));

endmodule
